lcd_timing_pattern_gen: RTL and testbench
=========================================

# lcd_timing_pattern_gen

Parametrised LCD video timing and test-pattern generator driving the 21-bit panel word (hsync, vsync, de, 6:6:6 RGB) into the 7:1 LVDS serializer. Generalises the fixed 1366x768 generator: all porch and sync sizes, sync polarity and colour depth are parameters. Adds runtime pattern modes, frame-boundary mode latching, start/stop control and a frame counter. Runs entirely in the pixel clock domain.

## Interface
- H_ACTIVE, 1366, visible pixels per line
- H_FP / H_SYNC / H_BP, 14 / 56 / 104, horizontal front porch / sync / back porch in pixels; H_TOTAL = sum of the four (1540)
- V_ACTIVE, 768, visible lines per frame
- V_FP / V_SYNC / V_BP, 3 / 5 / 4, vertical porch and sync in lines; V_TOTAL = sum of the four (780)
- SYNC_ACTIVE, 0, level of hsync/vsync while asserted
- COLOR_W, 6, bits per colour channel
- CHECK_LOG2, 5, checkerboard square size and moving-bar width = 2^CHECK_LOG2 pixels
- BAR_STEP, 4, moving-bar advance in pixels per frame
- clk  in  1  pixel clock
- rst_n  in  1  reset, asynchronous, active low
- enable  in  1  run request, sampled at frame wrap only
- mode  in  3  pattern select, latched at frame start
- solid_rgb  in  3*COLOR_W  {red, green, blue} for mode 0, latched with mode
- hsync, vsync  out  1  sync outputs, inactive level = ~SYNC_ACTIVE
- de  out  1  data enable, high for active pixels
- red, green, blue  out  COLOR_W each  pixel colour, 0 whenever de = 0
- frame_start  out  1  one-cycle pulse coincident with the outputs for pixel (0,0)
- frame_cnt  out  16  completed-frame counter, wraps at 2^16

## Operation
- Counters: h_cnt 0..H_TOTAL-1 and v_cnt 0..V_TOTAL-1. h_cnt wraps to 0 and increments v_cnt; v_cnt wraps to 0 at V_TOTAL-1 together with h_cnt wrap (frame wrap).
- Decoding for counter position (h,v): de = h<H_ACTIVE and v<V_ACTIVE. hsync asserted for H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC on every line, including blanking lines. vsync asserted for V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC; it changes only at h=0.
- States: IDLE (counters parked at 0,0; de=0; syncs inactive; RGB 0) and RUN. IDLE->RUN when enable=1, with the first counted position (0,0) on the next cycle. RUN->IDLE only at frame wrap with enable=0. Deasserting enable mid-frame completes the current frame.
- At every entry to (0,0): mode and solid_rgb are latched; bar_pos += BAR_STEP, or becomes 0 if the result would exceed H_ACTIVE-2^CHECK_LOG2; frame_cnt increments, except on the first frame after IDLE.
- Latched mode values:
  - 0: solid_rgb.
  - 1: eight vertical bars, in order white, yellow, cyan, green, magenta, red, blue, black. Bar k covers k*H_ACTIVE/8 <= h < (k+1)*H_ACTIVE/8, integer division at elaboration. Full scale = all ones.
  - 2: grey ramp, each channel = h[COLOR_W+1:2] (wraps every 4*2^COLOR_W pixels).
  - 3: checkerboard, white when h[CHECK_LOG2]^v[CHECK_LOG2]=0, else black.
  - 4: black field with a white vertical bar for bar_pos <= h < bar_pos+2^CHECK_LOG2.
  - 5-7: reserved, output black.
- Widths: counters are clog2(H_TOTAL) and clog2(V_TOTAL) bits. All comparisons are unsigned. No arithmetic on the counters other than +1.
- Reset: counters 0, state IDLE, hsync=vsync=~SYNC_ACTIVE, de=0, RGB=0, frame_start=0, frame_cnt=0, bar_pos=0, latched mode=0, latched colour=0. Asserting reset mid-frame forces these values immediately (asynchronously). After reset release the block restarts from IDLE.

## Timing
- Every output is registered. All outputs for counter position (h,v) appear together one cycle after the counter holds (h,v), so sync, de, colour and frame_start are mutually aligned with zero skew.
- Line period is exactly H_TOTAL cycles and frame period is exactly H_TOTAL*V_TOTAL cycles, with no extra wrap cycle.
- From enable=1 in IDLE: counters reach (0,0) on cycle 1; frame_start and the first de appear on cycle 2.
- Mode, solid_rgb and enable changes take effect at the next frame boundary only. The frame in progress is never altered.

## Test plan
- Reset and bring-up, with small parameters H=16/2/3/3, V=8/1/2/1: hold rst_n=0 -> hsync=vsync=1, de=0, RGB=0, frame_cnt=0. Release with enable=1 -> frame_start on cycle 2.
- Timing, with the same parameters: measure lines -> line period 24 cycles, de high 16 cycles per active line, hsync low for 3 cycles starting 18 cycles after de rise, vsync low for 2 lines starting at line 9, frame period 288 cycles, 8 de-lines per frame.
- Colour bars, mode=1 with defaults: sample line 0 -> colour changes at h=170,341,512,683,853,1024,1195; h=0 gives 0x3F/0x3F/0x3F; h=1365 gives 0/0/0.
- Mode switch mid-frame: change 3->0 with solid_rgb=0x3F,0,0 at v=100 -> checkerboard continues to the end of the frame; the next frame is solid red from its first pixel.
- Enable drop: enable=0 at v=200 -> frame completes, frame_cnt increments once, then de stays 0 and syncs stay inactive indefinitely. Re-enable -> frame_start after 2 cycles.
- Moving bar and async reset: mode=4 with defaults -> bar_pos 0,4,...,1332, then 0 on the next frame. Asserting rst_n=0 mid-line -> all outputs take reset values without waiting for a clk edge.

Source files
------------

// File: rtl/lcd_timing_pattern_gen.sv
// LCD video timing and test-pattern generator for the 7:1 LVDS panel word.
// Raster counters, frame-latched pattern select and frame accounting, all on the pixel clock.
module lcd_timing_pattern_gen #(
   parameter int H_ACTIVE    = 1366,
   parameter int H_FP        = 14,
   parameter int H_SYNC      = 56,
   parameter int H_BP        = 104,
   parameter int V_ACTIVE    = 768,
   parameter int V_FP        = 3,
   parameter int V_SYNC      = 5,
   parameter int V_BP        = 4,
   parameter bit SYNC_ACTIVE = 1'b0,
   parameter int COLOR_W     = 6,
   parameter int CHECK_LOG2  = 5,
   parameter int BAR_STEP    = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   enable,
   input  logic [2:0]             mode,
   input  logic [3*COLOR_W-1:0]   solid_rgb,
   output logic                   hsync,
   output logic                   vsync,
   output logic                   de,
   output logic [COLOR_W-1:0]     red,
   output logic [COLOR_W-1:0]     green,
   output logic [COLOR_W-1:0]     blue,
   output logic                   frame_start,
   output logic [15:0]            frame_cnt
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HW      = $clog2(H_TOTAL);
   localparam int VW      = $clog2(V_TOTAL);
   localparam int BAR_W   = 2 ** CHECK_LOG2;
   localparam int XW      = HW + VW + COLOR_W + CHECK_LOG2 + 2;

   localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
   localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
   localparam logic [XW-1:0] H_DE     = XW'(H_ACTIVE);
   localparam logic [XW-1:0] V_DE     = XW'(V_ACTIVE);
   localparam logic [XW-1:0] HS_BEG   = XW'(H_ACTIVE + H_FP);
   localparam logic [XW-1:0] HS_END   = XW'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [XW-1:0] VS_BEG   = XW'(V_ACTIVE + V_FP);
   localparam logic [XW-1:0] VS_END   = XW'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [XW-1:0] CK_MASK  = XW'(BAR_W);
   localparam logic [XW-1:0] BAR_MAX  = XW'(H_ACTIVE - BAR_W);
   localparam logic [COLOR_W-1:0] ON  = {COLOR_W{1'b1}};

   typedef enum logic {S_IDLE, S_RUN} state_t;

   state_t state_q, state_d;
   logic [HW-1:0] h_q, h_d;
   logic [VW-1:0] v_q, v_d;
   logic          enter_frame;
   logic          frame_done;
   logic          done_q;
   logic [2:0]    mode_q;
   logic [3*COLOR_W-1:0] rgb_q;
   logic [HW-1:0] bar_pos;

   always_comb begin
      state_d     = state_q;
      h_d         = h_q;
      v_d         = v_q;
      enter_frame = 1'b0;
      frame_done  = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            h_d = '0;
            v_d = '0;
            if (enable) begin
               state_d     = S_RUN;
               enter_frame = 1'b1;
            end
         end
         S_RUN: begin
            if (h_q == H_LAST) begin
               h_d = '0;
               if (v_q == V_LAST) begin
                  v_d        = '0;
                  frame_done = 1'b1;
                  if (enable) enter_frame = 1'b1;
                  else        state_d     = S_IDLE;
               end else begin
                  v_d = v_q + 1'b1;
               end
            end else begin
               h_d = h_q + 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         h_q     <= '0;
         v_q     <= '0;
      end else begin
         state_q <= state_d;
         h_q     <= h_d;
         v_q     <= v_d;
      end
   end

   logic [XW-1:0] h_x, v_x, bar_x, bar_sum;
   assign h_x     = XW'(h_q);
   assign v_x     = XW'(v_q);
   assign bar_x   = XW'(bar_pos);
   assign bar_sum = bar_x + XW'(BAR_STEP);

   // Pattern parameters change only on entry to (0,0) so a frame is never torn.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mode_q    <= '0;
         rgb_q     <= '0;
         bar_pos   <= '0;
         done_q    <= 1'b0;
         frame_cnt <= '0;
      end else begin
         done_q <= frame_done;
         if (done_q) frame_cnt <= frame_cnt + 16'd1;
         if (enter_frame) begin
            mode_q  <= mode;
            rgb_q   <= solid_rgb;
            bar_pos <= (bar_sum > BAR_MAX) ? '0 : HW'(bar_sum);
         end
      end
   end

   logic          de_c, hs_c, vs_c, in_bar, ck_c;
   logic [2:0]    bar_idx;
   logic [COLOR_W-1:0] r_c, g_c, b_c, grey;

   assign de_c   = (h_x < H_DE) && (v_x < V_DE);
   assign hs_c   = (h_x >= HS_BEG) && (h_x < HS_END);
   assign vs_c   = (v_x >= VS_BEG) && (v_x < VS_END);
   assign in_bar = (h_x >= bar_x) && (h_x < bar_x + XW'(BAR_W));
   assign ck_c   = ((h_x ^ v_x) & CK_MASK) != '0;
   assign grey   = COLOR_W'(h_x >> 2);

   always_comb begin
      bar_idx = '0;
      for (int k = 1; k < 8; k++)
         if (h_x >= XW'(k * H_ACTIVE / 8)) bar_idx = 3'(k);
   end

   always_comb begin
      r_c = '0;
      g_c = '0;
      b_c = '0;
      unique case (mode_q)
         3'd0: {r_c, g_c, b_c} = rgb_q;
         3'd1: begin
            // white,yellow,cyan,green,magenta,red,blue,black
            r_c = bar_idx[1] ? '0 : ON;
            g_c = bar_idx[2] ? '0 : ON;
            b_c = bar_idx[0] ? '0 : ON;
         end
         3'd2: {r_c, g_c, b_c} = {grey, grey, grey};
         3'd3: {r_c, g_c, b_c} = ck_c ? '0 : {ON, ON, ON};
         3'd4: {r_c, g_c, b_c} = in_bar ? {ON, ON, ON} : '0;
         default: {r_c, g_c, b_c} = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hsync       <= ~SYNC_ACTIVE;
         vsync       <= ~SYNC_ACTIVE;
         de          <= 1'b0;
         red         <= '0;
         green       <= '0;
         blue        <= '0;
         frame_start <= 1'b0;
      end else if (state_q == S_RUN) begin
         hsync       <= hs_c ? SYNC_ACTIVE : ~SYNC_ACTIVE;
         vsync       <= vs_c ? SYNC_ACTIVE : ~SYNC_ACTIVE;
         de          <= de_c;
         red         <= de_c ? r_c : '0;
         green       <= de_c ? g_c : '0;
         blue        <= de_c ? b_c : '0;
         frame_start <= (h_q == '0) && (v_q == '0);
      end else begin
         hsync       <= ~SYNC_ACTIVE;
         vsync       <= ~SYNC_ACTIVE;
         de          <= 1'b0;
         red         <= '0;
         green       <= '0;
         blue        <= '0;
         frame_start <= 1'b0;
      end
   end

endmodule

// File: tb/tb_lcd_timing_pattern_gen.sv
// Directed bench for lcd_timing_pattern_gen on a 24x12 raster (16x8 active).
module tb_lcd_timing_pattern_gen;

   localparam int CW = 6;

   logic          clk, rst_n, enable;
   logic [2:0]    mode;
   logic [3*CW-1:0] solid_rgb;
   logic          hsync, vsync, de, frame_start;
   logic [CW-1:0] red, green, blue;
   logic [15:0]   frame_cnt;

   lcd_timing_pattern_gen #(
      .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
      .V_ACTIVE(8), .V_FP(1), .V_SYNC(2), .V_BP(1),
      .SYNC_ACTIVE(1'b0), .COLOR_W(CW), .CHECK_LOG2(2), .BAR_STEP(4)
   ) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .mode(mode),
      .solid_rgb(solid_rgb), .hsync(hsync), .vsync(vsync), .de(de),
      .red(red), .green(green), .blue(blue),
      .frame_start(frame_start), .frame_cnt(frame_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   localparam logic [31:0] WHT = 32'h3FFFF;
   localparam logic [31:0] YEL = 32'h3FFC0;
   localparam logic [31:0] CYN = 32'h00FFF;
   localparam logic [31:0] GRN = 32'h00FC0;
   localparam logic [31:0] MAG = 32'h3F03F;
   localparam logic [31:0] RED = 32'h3F000;
   localparam logic [31:0] BLU = 32'h0003F;
   localparam logic [31:0] BLK = 32'h00000;

   int n_chk, n_pass;
   int t;
   int t5, t8, tr, cnt, bad;
   logic        de_a [288];
   logic        hs_a [288];
   logic        vs_a [288];
   logic        fs_a [288];
   logic [31:0] px_a [288];

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   function automatic logic [31:0] px();
      return 32'({red, green, blue});
   endfunction

   task automatic tick();
      @(negedge clk);
      t++;
   endtask

   task automatic wait_to(input int target);
      while (t < target) tick();
   endtask

   initial begin
      n_chk = 0; n_pass = 0; t = 0;
      rst_n = 1'b0; enable = 1'b0; mode = 3'd0; solid_rgb = '0;
      repeat (3) @(negedge clk);
      check("rst_hsync", 32'(hsync), 32'd1);
      check("rst_vsync", 32'(vsync), 32'd1);
      check("rst_de", 32'(de), 32'd0);
      check("rst_rgb", px(), BLK);
      check("rst_fcnt", 32'(frame_cnt), 32'd0);
      check("rst_fs", 32'(frame_start), 32'd0);

      // bring-up with colour bars
      rst_n = 1'b1; enable = 1'b1; mode = 3'd1;
      @(negedge clk);
      check("fs_cyc1", 32'(frame_start), 32'd0);
      check("de_cyc1", 32'(de), 32'd0);
      @(negedge clk);
      check("fs_cyc2", 32'(frame_start), 32'd1);
      check("de_cyc2", 32'(de), 32'd1);
      t = 0;
      for (int i = 0; i < 288; i++) begin
         de_a[i] = de; hs_a[i] = hsync; vs_a[i] = vsync;
         fs_a[i] = frame_start; px_a[i] = px();
         tick();
      end
      check("frame_period_fs", 32'(frame_start), 32'd1);
      check("fs_before_wrap", 32'(fs_a[287]), 32'd0);
      check("fcnt_f2", 32'(frame_cnt), 32'd1);

      check("de_h15", 32'(de_a[15]), 32'd1);
      check("de_h16", 32'(de_a[16]), 32'd0);
      check("line_period", 32'(de_a[24]), 32'd1);
      check("de_h23", 32'(de_a[23]), 32'd0);
      check("hs_h17", 32'(hs_a[17]), 32'd1);
      check("hs_h18", 32'(hs_a[18]), 32'd0);
      check("hs_h20", 32'(hs_a[20]), 32'd0);
      check("hs_h21", 32'(hs_a[21]), 32'd1);
      check("hs_blank_line", 32'(hs_a[8*24+18]), 32'd0);
      check("de_blank_line", 32'(de_a[8*24]), 32'd0);
      check("vs_before", 32'(vs_a[9*24-1]), 32'd1);
      check("vs_start", 32'(vs_a[9*24]), 32'd0);
      check("vs_last", 32'(vs_a[11*24-1]), 32'd0);
      check("vs_end", 32'(vs_a[11*24]), 32'd1);
      cnt = 0;
      for (int i = 0; i < 288; i++) if (de_a[i]) cnt++;
      check("de_total", 32'(cnt), 32'd128);
      cnt = 0;
      for (int l = 0; l < 12; l++) if (de_a[l*24]) cnt++;
      check("de_lines", 32'(cnt), 32'd8);
      cnt = 0;
      for (int i = 0; i < 288; i++) if (fs_a[i]) cnt++;
      check("fs_count", 32'(cnt), 32'd1);

      check("bar_h0", px_a[0], WHT);
      check("bar_h1", px_a[1], WHT);
      check("bar_h2", px_a[2], YEL);
      check("bar_h4", px_a[4], CYN);
      check("bar_h6", px_a[6], GRN);
      check("bar_h8", px_a[8], MAG);
      check("bar_h10", px_a[10], RED);
      check("bar_h13", px_a[13], BLU);
      check("bar_h15", px_a[15], BLK);
      check("bar_blank", px_a[17], BLK);

      // mode change mid-frame only takes effect at the next boundary
      mode = 3'd3;
      wait_to(290);
      check("f2_still_bars", px(), YEL);
      wait_to(576);
      check("ck_0_0", px(), WHT);
      wait_to(580);
      check("ck_4_0", px(), BLK);
      wait_to(648);
      mode = 3'd0; solid_rgb = {6'h3F, 6'h00, 6'h00};
      wait_to(676);
      check("ck_4_4", px(), WHT);
      wait_to(696);
      check("ck_0_5_after_sw", px(), BLK);
      wait_to(701);
      check("ck_5_5_after_sw", px(), WHT);
      wait_to(864);
      check("solid_first_px", px(), RED);
      check("fcnt_f4", 32'(frame_cnt), 32'd3);
      wait_to(880);
      check("solid_blank", px(), BLK);
      wait_to(1047);
      check("solid_last_px", px(), RED);

      // enable drop completes the frame, then stays idle
      enable = 1'b0;
      wait_to(1151);
      check("last_px_blank", 32'(de), 32'd0);
      wait_to(1152);
      check("idle_fs", 32'(frame_start), 32'd0);
      check("fcnt_after_drop", 32'(frame_cnt), 32'd4);
      bad = 0;
      for (int i = 0; i < 100; i++) begin
         if (de || !hsync || !vsync || frame_start || px() != BLK) bad++;
         tick();
      end
      check("idle_quiet", 32'(bad), 32'd0);
      check("fcnt_idle", 32'(frame_cnt), 32'd4);

      // re-enable with moving bar: bar_pos 0 -> 4 for this frame
      mode = 3'd4; enable = 1'b1;
      tick();
      check("reen_fs_c1", 32'(frame_start), 32'd0);
      tick();
      check("reen_fs_c2", 32'(frame_start), 32'd1);
      t5 = t;
      check("fcnt_reen", 32'(frame_cnt), 32'd4);
      wait_to(t5 + 3);
      check("mb5_h3", px(), BLK);
      wait_to(t5 + 4);
      check("mb5_h4", px(), WHT);
      wait_to(t5 + 7);
      check("mb5_h7", px(), WHT);
      wait_to(t5 + 8);
      check("mb5_h8", px(), BLK);
      wait_to(t5 + 288 + 7);
      check("mb6_h7", px(), BLK);
      wait_to(t5 + 288 + 8);
      check("mb6_h8", px(), WHT);
      wait_to(t5 + 576 + 11);
      check("mb7_h11", px(), BLK);
      wait_to(t5 + 576 + 15);
      check("mb7_h15", px(), WHT);
      t8 = t5 + 864;
      wait_to(t8);
      check("mb8_wrap_h0", px(), WHT);
      check("fcnt_f8", 32'(frame_cnt), 32'd7);
      wait_to(t8 + 2);
      check("mb8_h2", px(), WHT);

      // asynchronous reset between clock edges
      #2 rst_n = 1'b0;
      #1;
      check("arst_de", 32'(de), 32'd0);
      check("arst_rgb", px(), BLK);
      check("arst_hsync", 32'(hsync), 32'd1);
      check("arst_vsync", 32'(vsync), 32'd1);
      check("arst_fcnt", 32'(frame_cnt), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      check("rst2_fs_c1", 32'(frame_start), 32'd0);
      tick();
      check("rst2_fs_c2", 32'(frame_start), 32'd1);
      tr = t;
      wait_to(tr + 3);
      check("rst2_h3", px(), BLK);
      wait_to(tr + 4);
      check("rst2_h4", px(), WHT);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
